// File: rtl/rns_seq_pkg.sv
// Shared definitions for the RNS product-sum sequencer: state encoding,
// default geometry and the digit moduli used by reference models.
package rns_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DUMP,
        ST_DONE
    } seq_state_t;

    localparam int unsigned DEF_NUM_PRODS  = 16;
    localparam int unsigned DEF_NUM_DIGITS = 10;

    localparam int unsigned MODULI [DEF_NUM_DIGITS] = '{
        65536, 78125, 117649, 177147, 262027,
        262049, 262051, 262069, 262079, 262103
    };

endpackage

// File: rtl/rns_prod_sum_seq.sv
// Fast-clock sequencer driving digit-FIFO reads and MAC trunc/clear controls
// for a programmable number of NUM_PRODS-product batches.
module rns_prod_sum_seq
    import rns_seq_pkg::*;
#(
    parameter int unsigned NUM_PRODS   = DEF_NUM_PRODS,
    parameter int unsigned NUM_DIGITS  = DEF_NUM_DIGITS,
    parameter int unsigned TRUNC_START = 2,
    parameter int unsigned TRUNC_END   = NUM_PRODS - 3,
    parameter int unsigned BATCH_W     = 16,
    localparam int unsigned PCW        = $clog2(NUM_PRODS)
) (
    input  logic                  f_clk,
    input  logic                  f_async_clr_n,
    input  logic                  start,
    input  logic [BATCH_W-1:0]    num_batches,
    input  logic                  abort,
    input  logic [NUM_DIGITS-1:0] in_empty,
    input  logic [NUM_DIGITS-1:0] out_full,
    output logic                  data_in_rd_req,
    output logic                  trunc_ena,
    output logic                  clear_ena,
    output logic                  busy,
    output logic                  done,
    output logic [BATCH_W-1:0]    batch_cnt,
    output logic [PCW-1:0]        prod_cnt,
    output logic [15:0]           stall_cnt
);

    seq_state_t         state, state_nxt;
    logic [BATCH_W-1:0] captured;
    logic               any_empty, any_full;
    logic               last_prod, last_batch, accept;

    always_ff @(posedge f_clk or negedge f_async_clr_n) begin
        if (!f_async_clr_n) state <= ST_IDLE;
        else                state <= state_nxt;
    end

    always_comb begin
        any_empty      = |in_empty;
        any_full       = |out_full;
        last_prod      = (prod_cnt == PCW'(NUM_PRODS - 1));
        last_batch     = (batch_cnt == captured - BATCH_W'(1));
        accept         = (state == ST_IDLE) && start && !abort;
        data_in_rd_req = (state == ST_LOAD) && !any_empty;
        trunc_ena      = (state == ST_LOAD) &&
                         (prod_cnt >= PCW'(TRUNC_START)) &&
                         (prod_cnt <  PCW'(TRUNC_END));
        // Tied to the actual read so a stall on the final product withholds it.
        clear_ena      = data_in_rd_req && last_prod;
        busy           = (state == ST_LOAD) || (state == ST_DUMP);
        done           = (state == ST_DONE);

        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = (num_batches != '0) ? ST_LOAD : ST_DONE;
            ST_LOAD: if (data_in_rd_req && last_prod) state_nxt = ST_DUMP;
            ST_DUMP: if (!any_full) state_nxt = last_batch ? ST_DONE : ST_LOAD;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (abort) state_nxt = ST_IDLE;
    end

    always_ff @(posedge f_clk or negedge f_async_clr_n) begin
        if (!f_async_clr_n) begin
            captured  <= '0;
            batch_cnt <= '0;
            prod_cnt  <= '0;
            stall_cnt <= '0;
        end else if (accept) begin
            captured  <= num_batches;
            batch_cnt <= '0;
            prod_cnt  <= '0;
            stall_cnt <= '0;
        end else if (state == ST_LOAD) begin
            // Reads in the abort cycle still advance the product index.
            if (data_in_rd_req)
                prod_cnt <= last_prod ? '0 : prod_cnt + PCW'(1);
            else if (stall_cnt != '1)
                stall_cnt <= stall_cnt + 16'd1;
        end else if (state == ST_DUMP) begin
            if (any_full) begin
                if (stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
            end else if (!abort && !last_batch) begin
                batch_cnt <= batch_cnt + BATCH_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rns_prod_sum_seq.sv
// Self-checking bench for rns_prod_sum_seq: behavioural batch model compared
// every cycle, plus directed scenarios with hand-computed timing.
module tb_rns_prod_sum_seq;
    import rns_seq_pkg::*;

    localparam int NP = DEF_NUM_PRODS;
    localparam int ND = DEF_NUM_DIGITS;
    localparam int TS = 2;
    localparam int TE = NP - 3;

    logic          f_clk = 1'b0;
    logic          f_async_clr_n = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   num_batches = '0;
    logic          abort = 1'b0;
    logic [ND-1:0] in_empty = '0;
    logic [ND-1:0] out_full = '0;
    logic          data_in_rd_req, trunc_ena, clear_ena, busy, done;
    logic [15:0]   batch_cnt;
    logic [3:0]    prod_cnt;
    logic [15:0]   stall_cnt;

    rns_prod_sum_seq #(.NUM_PRODS(NP), .NUM_DIGITS(ND)) dut (
        .f_clk(f_clk), .f_async_clr_n(f_async_clr_n), .start(start),
        .num_batches(num_batches), .abort(abort), .in_empty(in_empty),
        .out_full(out_full), .data_in_rd_req(data_in_rd_req),
        .trunc_ena(trunc_ena), .clear_ena(clear_ena), .busy(busy), .done(done),
        .batch_cnt(batch_cnt), .prod_cnt(prod_cnt), .stall_cnt(stall_cnt)
    );

    always #5 f_clk = ~f_clk;

    int checks = 0;
    int fails  = 0;

    function automatic void check(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Model: mode 0 idle, 1 running, 2 done pulse. pos 0..NP-1 are the read
    // slots of a batch, pos NP is the dump gap.
    int m_mode, m_pos, m_batch, m_total, m_stall;
    bit m_emp, m_full;

    always @(posedge f_clk or negedge f_async_clr_n) begin
        if (!f_async_clr_n) begin
            m_mode = 0; m_pos = 0; m_batch = 0; m_total = 0; m_stall = 0;
        end else begin
            m_emp  = |in_empty;
            m_full = |out_full;
            case (m_mode)
                0: if (start && !abort) begin
                       m_total = num_batches; m_batch = 0; m_pos = 0; m_stall = 0;
                       m_mode  = (num_batches != 0) ? 1 : 2;
                   end
                1: if (m_pos < NP) begin
                       if (!m_emp) m_pos++;
                       else if (m_stall < 65535) m_stall++;
                   end else if (m_full) begin
                       if (m_stall < 65535) m_stall++;
                   end else if (!abort) begin
                       if (m_batch == m_total - 1) m_mode = 2;
                       else begin m_batch++; m_pos = 0; end
                   end
                default: m_mode = 0;
            endcase
            if (abort) m_mode = 0;
        end
    end

    // Compare process and event logging (cycle offsets relative to start).
    int cyc = 0, start_cyc = 0, done_cyc = -1;
    bit done_seen = 0, busy_seen = 0;
    int rd_log[$], clr_log[$], trunc_log[$];
    bit e_rd;

    always @(negedge f_clk) begin
        cyc++;
        e_rd = (m_mode == 1) && (m_pos < NP) && !(|in_empty);
        check("rd_req",   data_in_rd_req, e_rd);
        check("trunc",    trunc_ena, (m_mode == 1) && m_pos >= TS && m_pos < TE);
        check("clear",    clear_ena, e_rd && m_pos == NP - 1);
        check("busy",     busy, m_mode == 1);
        check("done",     done, m_mode == 2);
        check("batch",    batch_cnt, m_batch);
        check("prod",     prod_cnt, m_pos % NP);
        check("stall",    stall_cnt, m_stall);
        if (start) begin
            start_cyc = cyc; done_cyc = -1; done_seen = 0; busy_seen = 0;
            rd_log.delete(); clr_log.delete(); trunc_log.delete();
        end
        if (data_in_rd_req) rd_log.push_back(cyc - start_cyc);
        if (clear_ena)      clr_log.push_back(cyc - start_cyc);
        if (trunc_ena)      trunc_log.push_back(cyc - start_cyc);
        if (busy)           busy_seen = 1;
        if (done) begin done_seen = 1; done_cyc = cyc - start_cyc; end
    end

    task automatic tick();
        @(posedge f_clk); #1;
    endtask

    task automatic do_start(int nb);
        start = 1'b1; num_batches = 16'(nb);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(int max);
        int n = 0;
        while (!done_seen && n < max) begin tick(); n++; end
        checks++;
        if (!done_seen) begin
            fails++;
            $display("FAIL wait_done: no done within %0d cycles", max);
        end
    endtask

    task automatic check_single_batch(string tag);
        check({tag, "_reads"}, rd_log.size(), 16);
        check({tag, "_first_rd"}, rd_log.size() > 0 ? rd_log[0] : -1, 1);
        check({tag, "_trunc_n"}, trunc_log.size(), 11);
        check({tag, "_trunc_first"}, trunc_log.size() > 0 ? trunc_log[0] : -1, 3);
        check({tag, "_clears"}, clr_log.size(), 1);
        check({tag, "_clear_cyc"}, clr_log.size() > 0 ? clr_log[0] : -1, 16);
        check({tag, "_done_cyc"}, done_cyc, 18);
        check({tag, "_stall"}, stall_cnt, 0);
    endtask

    initial begin
        repeat (3) @(posedge f_clk);
        #1;
        check("reset_rd", data_in_rd_req, 0);
        check("reset_busy", busy, 0);
        check("reset_stall", stall_cnt, 0);
        f_async_clr_n = 1'b1;
        tick();

        // Single batch, no stalls.
        do_start(1);
        wait_done(40);
        check_single_batch("single");
        tick();

        // Three batches back to back.
        do_start(3);
        wait_done(80);
        check("three_reads", rd_log.size(), 48);
        check("three_clears", clr_log.size(), 3);
        if (clr_log.size() == 3) begin
            check("three_clr0", clr_log[0], 16);
            check("three_clr1", clr_log[1], 33);
            check("three_clr2", clr_log[2], 50);
        end
        check("three_done", done_cyc, 52);
        check("three_batch", batch_cnt, 2);
        tick();

        // Input stall on the final product.
        do_start(1);
        repeat (15) tick();
        in_empty[7] = 1'b1;
        repeat (5) tick();
        in_empty = '0;
        wait_done(40);
        check("stall_reads", rd_log.size(), 16);
        check("stall_clears", clr_log.size(), 1);
        check("stall_clr_cyc", clr_log.size() > 0 ? clr_log[0] : -1, 21);
        check("stall_done", done_cyc, 23);
        check("stall_cnt5", stall_cnt, 5);
        tick();

        // Result backpressure during the dump gap.
        do_start(2);
        repeat (16) tick();
        out_full[0] = 1'b1;
        repeat (4) tick();
        out_full = '0;
        wait_done(60);
        check("bp_reads", rd_log.size(), 32);
        check("bp_rd16", rd_log.size() > 16 ? rd_log[16] : -1, 22);
        check("bp_done", done_cyc, 39);
        check("bp_stall", stall_cnt, 4);
        tick();

        // Zero batches.
        do_start(0);
        wait_done(5);
        check("zero_done", done_cyc, 1);
        check("zero_reads", rd_log.size(), 0);
        check("zero_busy", busy_seen, 0);
        tick();

        // Abort at product 7 of the second batch.
        do_start(3);
        repeat (24) tick();
        check("abort_pre_batch", batch_cnt, 1);
        check("abort_pre_prod", prod_cnt, 7);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_rd", data_in_rd_req, 0);
        check("abort_prod", prod_cnt, 8);
        repeat (30) tick();
        check("abort_no_done", done_seen, 0);

        // Asynchronous reset mid-LOAD.
        do_start(2);
        repeat (10) tick();
        #2 f_async_clr_n = 1'b0;
        #1;
        check("arst_rd", data_in_rd_req, 0);
        check("arst_busy", busy, 0);
        check("arst_prod", prod_cnt, 0);
        @(negedge f_clk);
        f_async_clr_n = 1'b1;
        tick();
        do_start(1);
        wait_done(40);
        check_single_batch("post_rst");
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            start       = ($urandom % 8) == 0;
            num_batches = 16'($urandom % 4);
            abort       = ($urandom % 64) == 0;
            in_empty    = '0;
            out_full    = '0;
            if ($urandom % 4 == 0) in_empty[$urandom_range(ND - 1)] = 1'b1;
            if ($urandom % 3 == 0) out_full[$urandom_range(ND - 1)] = 1'b1;
            tick();
        end
        start = 1'b0; abort = 1'b0; in_empty = '0; out_full = '0;
        repeat (100) tick();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
